hexa7seg_multi: RTL and testbench

Parametrised multi-digit hexadecimal display driver for the DE0-CV seven-segment bank. It captures a packed N-digit value on a load strobe and decodes every digit over the full 0–F range. It adds per-digit forced blanking, per-digit blinking from an internal prescaler, and optional leading-zero suppression, and registers all segment outputs. It sits between datapath result registers and the HEXn board pins.

---
 rtl/hexa7seg_pkg.sv | 33 +++
 rtl/hexa7seg_digit.sv | 15 +
 rtl/hexa7seg_multi.sv | 77 +++++++
 tb/tb_hexa7seg_multi.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hexa7seg_pkg.sv
// hexa7seg_pkg: segment pattern table, dark pattern and decode helper for the hex display driver
package hexa7seg_pkg;

    localparam logic [6:0] SEG_DARK = 7'b1111111;

    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0001110,
        7'b0000110,
        7'b0100001,
        7'b1000110,
        7'b0000011,
        7'b0001000,
        7'b0010000,
        7'b0000000,
        7'b1111000,
        7'b0000010,
        7'b0010010,
        7'b0011001,
        7'b0110000,
        7'b0100100,
        7'b1111001,
        7'b1000000
    };

    function automatic logic [6:0] seg_pattern(input logic [3:0] nibble, input logic active_low);
        return active_low ? SEG_TABLE[nibble] : ~SEG_TABLE[nibble];
    endfunction

    function automatic logic [6:0] seg_dark(input logic active_low);
        return active_low ? SEG_DARK : ~SEG_DARK;
    endfunction

endpackage

// File: rtl/hexa7seg_digit.sv
// hexa7seg_digit: combinational nibble to seven-segment decoder with a forced-dark input
module hexa7seg_digit
    import hexa7seg_pkg::*;
#(
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic [3:0] nibble_i,
    input  logic       dark_i,
    output logic [6:0] seg_o
);

    // dark overrides the decoded glyph
    always_comb seg_o = dark_i ? seg_dark(ACTIVE_LOW) : seg_pattern(nibble_i, ACTIVE_LOW);

endmodule

// File: rtl/hexa7seg_multi.sv
// hexa7seg_multi: multi-digit hex display driver with blanking, blinking and leading-zero suppression
module hexa7seg_multi
    import hexa7seg_pkg::*;
#(
    parameter int N_DIGITS  = 6,
    parameter int BLINK_DIV = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  load_i,
    input  logic [4*N_DIGITS-1:0] value_i,
    input  logic [N_DIGITS-1:0]   blank_mask_i,
    input  logic [N_DIGITS-1:0]   blink_mask_i,
    input  logic                  lz_blank_i,
    output logic [7*N_DIGITS-1:0] display_o,
    output logic                  blink_phase_o
);

    localparam int CW = $clog2(BLINK_DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(BLINK_DIV - 1);

    logic [4*N_DIGITS-1:0] val_q, val_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  phase_q, phase_d;
    logic                  zero_run;
    logic [N_DIGITS-1:0]   dark;
    logic [7*N_DIGITS-1:0] display_q, display_d;

    // load restarts the prescaler so a fresh value is visible at once
    always_comb begin
        val_d   = load_i ? value_i : val_q;
        cnt_d   = (load_i || cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
        phase_d = load_i ? 1'b0 : phase_q ^ (cnt_q == CNT_MAX);
    end

    // darkness per digit: forced blank, blink phase, then leading zeros scanned from the MSB
    always_comb begin
        zero_run = 1'b1;
        dark     = '0;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (val_q[4*i +: 4] == 4'd0);
            dark[i]  = blank_mask_i[i] || (blink_mask_i[i] && phase_q) || (lz_blank_i && i != 0 && zero_run);
        end
    end

    for (genvar g = 0; g < N_DIGITS; g++) begin : gen_digit
        hexa7seg_digit #(.ACTIVE_LOW(ACTIVE_LOW)) u_digit (
            .nibble_i (val_q[4*g +: 4]),
            .dark_i   (dark[g]),
            .seg_o    (display_d[7*g +: 7])
        );
    end

    // holding register and blink prescaler
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            val_q   <= '0;
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            val_q   <= val_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    // registered segment outputs, dark while in reset
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) display_q <= {N_DIGITS{seg_dark(ACTIVE_LOW)}};
        else display_q <= display_d;
    end

    assign display_o     = display_q;
    assign blink_phase_o = phase_q;

endmodule

// File: tb/tb_hexa7seg_multi.sv
// tb_hexa7seg_multi: scoreboard bench for the multi-digit hex display driver
module tb_hexa7seg_multi;

    localparam logic [6:0] DK = 7'b1111111;
    localparam logic [6:0] SEG [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load = 1'b0;
    logic [23:0] value = '0;
    logic [5:0]  blank_mask = '0;
    logic [5:0]  blink_mask = '0;
    logic        lz_blank = 1'b0;
    logic [41:0] display;
    logic        blink_phase;
    logic        pol_load = 1'b0;
    logic [3:0]  pol_value = '0;
    logic [6:0]  pol_display;
    logic        pol_phase;

    int          checks = 0;
    int          failures = 0;
    logic [41:0] sb [$];
    logic [41:0] e;
    logic [23:0] m_val = '0;
    int          m_cnt = 0;
    logic        m_phase = 1'b0;

    always #5 clk = ~clk;

    hexa7seg_multi #(.N_DIGITS(6), .BLINK_DIV(4), .ACTIVE_LOW(1'b1)) u_dut (
        .clock_i       (clk),
        .reset_i       (reset),
        .load_i        (load),
        .value_i       (value),
        .blank_mask_i  (blank_mask),
        .blink_mask_i  (blink_mask),
        .lz_blank_i    (lz_blank),
        .display_o     (display),
        .blink_phase_o (blink_phase)
    );

    hexa7seg_multi #(.N_DIGITS(1), .BLINK_DIV(4), .ACTIVE_LOW(1'b0)) u_pol (
        .clock_i       (clk),
        .reset_i       (reset),
        .load_i        (pol_load),
        .value_i       (pol_value),
        .blank_mask_i  (1'b0),
        .blink_mask_i  (1'b0),
        .lz_blank_i    (1'b0),
        .display_o     (pol_display),
        .blink_phase_o (pol_phase)
    );

    function automatic logic [41:0] model_disp(input logic [23:0] v, input logic [5:0] bm,
                                               input logic [5:0] km, input logic ph, input logic lz);
        logic [41:0] d;
        logic        z;
        d = '0;
        z = 1'b1;
        for (int i = 5; i >= 0; i--) begin
            z = z && (v[4*i +: 4] == 4'd0);
            d[7*i +: 7] = (bm[i] || (km[i] && ph) || (lz && i > 0 && z)) ? DK : SEG[v[4*i +: 4]];
        end
        return d;
    endfunction

    function automatic logic [41:0] pop_exp();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic step();
        sb.push_back(model_disp(m_val, blank_mask, blink_mask, m_phase, lz_blank));
        if (load) begin
            m_val = value;
            m_cnt = 0;
            m_phase = 1'b0;
        end else if (m_cnt == 3) begin
            m_cnt = 0;
            m_phase = ~m_phase;
        end else m_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        sb.delete();
        m_val = '0;
        m_cnt = 0;
        m_phase = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        clear_model();
        value = 24'h123456;
        load = 1'b1;
        step();
        e = pop_exp();
        load = 1'b0;
        repeat (2) begin
            step();
            e = pop_exp();
        end
        #3;
        reset = 1'b1;
        #1;
        clear_model();
        checks++;
        if (display !== {42{1'b1}}) begin
            failures++;
            $display("FAIL reset_dark: got %h expected %h", display, {42{1'b1}});
        end
        checks++;
        if (blink_phase !== 1'b0) begin
            failures++;
            $display("FAIL reset_phase: got %b expected 0", blink_phase);
        end
        checks++;
        if (pol_display !== 7'b0000000) begin
            failures++;
            $display("FAIL reset_pol_dark: got %b expected 0000000", pol_display);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display !== {6{7'b1000000}}) begin
            failures++;
            $display("FAIL reset_first_edge: got %h expected %h", display, e);
        end
        lz_blank = 1'b1;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display !== {{5{DK}}, 7'b1000000}) begin
            failures++;
            $display("FAIL reset_lz_single0: got %h expected %h", display, e);
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_decode();
        value = 24'h89ABCD;
        load = 1'b1;
        step();
        e = pop_exp();
        checks++;
        if (display !== e) begin
            failures++;
            $display("FAIL decode_load_edge: got %h expected %h", display, e);
        end
        load = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display[6:0] !== 7'b0100001 || display[41:35] !== 7'b0000000) begin
            failures++;
            $display("FAIL decode_89ABCD: got %h expected %h", display, e);
        end
        value = 24'hEF0123;
        load = 1'b1;
        step();
        e = pop_exp();
        load = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display[6:0] !== 7'b0110000 || display[41:35] !== 7'b0000110) begin
            failures++;
            $display("FAIL decode_EF0123: got %h expected %h", display, e);
        end
    endtask

    task automatic test_leading_zero();
        lz_blank = 1'b1;
        value = 24'h000A05;
        load = 1'b1;
        step();
        e = pop_exp();
        load = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display !== {DK, DK, DK, 7'b0001000, 7'b1000000, 7'b0010010}) begin
            failures++;
            $display("FAIL lz_000A05: got %h expected %h", display, e);
        end
        value = 24'h000000;
        load = 1'b1;
        step();
        e = pop_exp();
        load = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display !== {{5{DK}}, 7'b1000000}) begin
            failures++;
            $display("FAIL lz_zero: got %h expected %h", display, e);
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_blink();
        blink_mask = 6'b000001;
        value = 24'h123456;
        load = 1'b1;
        step();
        e = pop_exp();
        load = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step();
            e = pop_exp();
            checks++;
            if (display !== e) begin
                failures++;
                $display("FAIL blink_cycle%0d: got %h expected %h", i, display, e);
            end
            checks++;
            if (blink_phase !== m_phase) begin
                failures++;
                $display("FAIL blink_phase%0d: got %b expected %b", i, blink_phase, m_phase);
            end
        end
        for (int i = 0; i < 8 && m_phase == 1'b0; i++) begin
            step();
            e = pop_exp();
        end
        value = 24'h654321;
        load = 1'b1;
        step();
        e = pop_exp();
        load = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (blink_phase !== 1'b0 || display[6:0] !== 7'b1111001 || display !== e) begin
            failures++;
            $display("FAIL blink_load_restart: got phase %b disp %h expected phase 0 disp %h", blink_phase, display, e);
        end
        blink_mask = '0;
    endtask

    task automatic test_priority();
        value = 24'h000300;
        load = 1'b1;
        blank_mask = 6'b000100;
        blink_mask = 6'b000100;
        step();
        e = pop_exp();
        load = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            e = pop_exp();
            checks++;
            if (display !== e || display[20:14] !== DK) begin
                failures++;
                $display("FAIL prio_dark%0d: got %h expected %h", i, display, e);
            end
        end
        blank_mask = '0;
        blink_mask = '0;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display[20:14] !== 7'b0110000) begin
            failures++;
            $display("FAIL prio_release: got %h expected %h", display, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] vals [3];
        vals = '{24'h111111, 24'h222222, 24'hABCDEF};
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            value = vals[i];
            step();
            e = pop_exp();
            checks++;
            if (display !== e) begin
                failures++;
                $display("FAIL b2b_load%0d: got %h expected %h", i, display, e);
            end
        end
        load = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (display !== e || display[6:0] !== 7'b0001110 || display[41:35] !== 7'b0001000 || blink_phase !== 1'b0) begin
            failures++;
            $display("FAIL b2b_final: got %h phase %b expected %h phase 0", display, blink_phase, e);
        end
    endtask

    task automatic test_polarity();
        checks++;
        if (pol_display !== 7'b0111111) begin
            failures++;
            $display("FAIL pol_zero: got %b expected 0111111", pol_display);
        end
        pol_value = 4'h8;
        pol_load = 1'b1;
        step();
        e = pop_exp();
        pol_load = 1'b0;
        step();
        e = pop_exp();
        checks++;
        if (pol_display !== 7'b1111111) begin
            failures++;
            $display("FAIL pol_eight: got %b expected 1111111", pol_display);
        end
        #2;
        reset = 1'b1;
        #1;
        clear_model();
        checks++;
        if (pol_display !== 7'b0000000) begin
            failures++;
            $display("FAIL pol_reset: got %b expected 0000000", pol_display);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_leading_zero();
        test_blink();
        test_priority();
        test_back_to_back();
        test_polarity();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
